pix_stream_packer: RTL and testbench

- Receive end of the filter2d pixel stream: accepts one 8-bit pixel per i_strb pulse from the filter output (o_strb/o_data side).
- Tracks column/row position within the frame.
- Packs 4 consecutive pixels into a 32-bit word.
- Buffers words in a small FIFO and presents them downstream on a valid/ready handshake with end-of-line / end-of-frame tags. Sits between filter2d and the bus/DMA writer.

---
 rtl/pix_stream_packer.sv | 250 +++++++++++++++++++++++++
 tb/tb_pix_stream_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_stream_packer.sv
// pix_stream_packer
// Receive side of the filter2d pixel stream. Each strobed 8-bit pixel is
// placed into a 4-byte pack register while column/row position is tracked.
// Every fourth pixel completes a 32-bit word, which is pushed into a small
// circular FIFO. Each word is tagged with end-of-line and end-of-frame flags.
// The FIFO head is offered downstream on a valid/ready handshake.
// Upstream cannot be stalled, so a word that arrives at a full FIFO is dropped
// and the sticky overflow flag is set. Framing keeps advancing regardless.
//
// Optional feature: define PIX_FRAME_SUM_EN to add a per-frame pixel sum
// (o_sum / o_sum_strb).

module pix_stream_packer #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_clr,
  input  logic                        i_strb,
  input  logic [7:0]                  i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [31:0]                 o_word,
  output logic                        o_eol,
  output logic                        o_eof,
  output logic                        o_ovf,
  output logic [$clog2(FIFO_DEPTH):0] o_level
`ifdef PIX_FRAME_SUM_EN
  ,
  output logic [23:0]                 o_sum,
  output logic                        o_sum_strb
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  // FIFO entry layout: {eof, eol, word[31:0]}
  localparam int EW = 34;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Position tracking and pack register
  // ------------------------------------------------------------------
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic [1:0]    byte_idx_reg, byte_idx_next;
  logic [7:0]    lane_reg [3];

  logic strb_take;
  logic col_last;
  logic row_last;
  logic word_done;
  logic tag_eol;
  logic tag_eof;

  // A clear in the same cycle wins over a strobe, so the strobe is masked here.
  assign strb_take = i_strb & ~i_clr;
  assign col_last  = (col_reg == COL_LAST);
  assign row_last  = (row_reg == ROW_LAST);
  assign word_done = strb_take & (byte_idx_reg == 2'd3);
  assign tag_eol   = col_last;
  assign tag_eof   = col_last & row_last;

  // Next column/row/byte position for an accepted pixel; frames wrap without a gap.
  always_comb begin
    col_next      = col_reg;
    row_next      = row_reg;
    byte_idx_next = byte_idx_reg;
    if (strb_take) begin
      byte_idx_next = byte_idx_reg + 2'd1;
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  // Position registers; reset or clear restart at the top-left pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg      <= '0;
      row_reg      <= '0;
      byte_idx_reg <= '0;
    end else if (i_clr) begin
      col_reg      <= '0;
      row_reg      <= '0;
      byte_idx_reg <= '0;
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      byte_idx_reg <= byte_idx_next;
    end
  end

  // Only lanes 0..2 are stored; lane 3 is taken straight from i_data on the push.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    // Capture the pixel into its byte lane when the byte index selects it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_reg[gi] <= '0;
      end else if (i_clr) begin
        lane_reg[gi] <= '0;
      end else if (strb_take && (byte_idx_reg == 2'(gi))) begin
        lane_reg[gi] <= i_data;
      end
    end
  end

  // ------------------------------------------------------------------
  // Word FIFO
  // ------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          ovf_reg, ovf_next;
  logic [EW-1:0] hold_reg;

  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LVL_FULL);
  assign push_entry = {tag_eof, tag_eol, i_data, lane_reg[2], lane_reg[1], lane_reg[0]};
  assign head_entry = fifo_mem[rd_ptr_reg];

  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign do_pop  = ~fifo_empty & i_ready & ~i_clr;
  assign do_push = word_done & (~fifo_full | do_pop);
  assign drop    = word_done & fifo_full & ~do_pop;

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    ovf_next    = ovf_reg | drop;
    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage array is left unreset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  // FIFO control registers; reset/clear discards every buffered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (i_clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Track the current head so the outputs hold the last word once the FIFO drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (i_clr) begin
      hold_reg <= '0;
    end else if (!fifo_empty) begin
      hold_reg <= head_entry;
    end
  end

  // Outputs are driven only by registered state; i_ready has no path to them.
  assign o_valid = ~fifo_empty;
  assign o_word  = fifo_empty ? hold_reg[31:0] : head_entry[31:0];
  assign o_eol   = fifo_empty ? hold_reg[32]   : head_entry[32];
  assign o_eof   = fifo_empty ? hold_reg[33]   : head_entry[33];
  assign o_ovf   = ovf_reg;
  assign o_level = level_reg;

`ifdef PIX_FRAME_SUM_EN
  // ------------------------------------------------------------------
  // Per-frame pixel sum; dropped words still contribute
  // ------------------------------------------------------------------
  logic [23:0] acc_reg;
  logic [23:0] sum_reg;
  logic        sum_strb_reg;
  logic [23:0] acc_plus;

  assign acc_plus = acc_reg + {16'd0, i_data};

  // Accumulate every accepted pixel; publish the total and restart on the frame's last pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg      <= '0;
      sum_reg      <= '0;
      sum_strb_reg <= 1'b0;
    end else if (i_clr) begin
      acc_reg      <= '0;
      sum_reg      <= '0;
      sum_strb_reg <= 1'b0;
    end else begin
      sum_strb_reg <= 1'b0;
      if (strb_take) begin
        if (word_done && tag_eof) begin
          sum_reg      <= acc_plus;
          acc_reg      <= '0;
          sum_strb_reg <= 1'b1;
        end else begin
          acc_reg <= acc_plus;
        end
      end
    end
  end

  assign o_sum      = sum_reg;
  assign o_sum_strb = sum_strb_reg;
`endif

endmodule

// File: tb/tb_pix_stream_packer.sv
// tb_pix_stream_packer
// Randomised scoreboard bench. The stimulus process runs a frame-position
// model: each word is its 4 pixels, and its eol/eof tags come from the pixel
// index within the frame. The model also decides whether a word fits in the
// FIFO or is dropped. Expected words go into a queue, and a monitor on the
// falling edge pops and compares them whenever the DUT hands a word over.
// Small image dimensions keep full-frame runs short.

module tb_pix_stream_packer;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_clr = 1'b0;
  logic          i_strb = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_valid;
  logic [31:0]   o_word;
  logic          o_eol;
  logic          o_eof;
  logic          o_ovf;
  logic [LW-1:0] o_level;
`ifdef PIX_FRAME_SUM_EN
  logic [23:0]   o_sum;
  logic          o_sum_strb;
`endif

  pix_stream_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (i_clr),
    .i_strb  (i_strb),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_word  (o_word),
    .o_eol   (o_eol),
    .o_eof   (o_eof),
    .o_ovf   (o_ovf),
    .o_level (o_level)
`ifdef PIX_FRAME_SUM_EN
    ,
    .o_sum      (o_sum),
    .o_sum_strb (o_sum_strb)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        eol;
    logic        eof;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] grp[$];
  int         pix_pos = 0;
  bit         ovf_m = 1'b0;
  bit         ovf_cur = 1'b0;
  int         lvl_cur = 0;
  int         total = 0;
  int         bad = 0;
  logic [23:0] acc_m = '0;
  logic [23:0] sum_m = '0;
  logic [23:0] sum_cur = '0;
  bit          sum_strb_m = 1'b0;
  bit          sum_strb_cur = 1'b0;

  task automatic clear_model();
    exp_q.delete();
    grp.delete();
    pix_pos    = 0;
    ovf_m      = 1'b0;
    acc_m      = '0;
    sum_m      = '0;
    sum_strb_m = 1'b0;
  endtask

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic step(input bit strb, input logic [7:0] data, input bit rdy, input bit clr);
    int   lvl;
    bit   pop;
    ent_t e;
    lvl          = exp_q.size();
    lvl_cur      = lvl;
    ovf_cur      = ovf_m;
    sum_cur      = sum_m;
    sum_strb_cur = sum_strb_m;
    i_strb  = strb;
    i_data  = data;
    i_clr   = clr;
    i_ready = clr ? 1'b0 : rdy;
    if (clr) begin
      clear_model();
    end else begin
      pop        = (lvl > 0) && rdy;
      sum_strb_m = 1'b0;
      if (strb) begin
        grp.push_back(data);
        acc_m = acc_m + {16'd0, data};
        if (pix_pos == W * H - 1) begin
          sum_m      = acc_m;
          acc_m      = '0;
          sum_strb_m = 1'b1;
        end
        if (grp.size() == 4) begin
          e.w   = {grp[3], grp[2], grp[1], grp[0]};
          e.eol = ((pix_pos % W) == W - 1);
          e.eof = (pix_pos == W * H - 1);
          grp.delete();
          if (lvl == D && !pop) ovf_m = 1'b1;
          else exp_q.push_back(e);
        end
        pix_pos = (pix_pos + 1) % (W * H);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
  task automatic pulse_reset();
    i_strb  = 1'b0;
    i_ready = 1'b0;
    i_clr   = 1'b0;
    reset   = 1'b1;
    #1;
    total++;
    if ({o_valid, o_word, o_eol, o_eof, o_ovf, o_level} !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b w=%h eol=%0b eof=%0b ovf=%0b lvl=%0d want all zero",
               o_valid, o_word, o_eol, o_eof, o_ovf, o_level);
    end
    clear_model();
    lvl_cur      = 0;
    ovf_cur      = 1'b0;
    sum_cur      = '0;
    sum_strb_cur = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: check occupancy/flags every cycle and compare each handed-over word.
  always @(negedge clk) begin
    ent_t e;
    total++;
    if (o_level !== LW'(lvl_cur) || o_valid !== (lvl_cur != 0) || o_ovf !== ovf_cur) begin
      bad++;
      $display("FAIL level: got lvl=%0d v=%0b ovf=%0b want lvl=%0d v=%0b ovf=%0b",
               o_level, o_valid, o_ovf, lvl_cur, (lvl_cur != 0), ovf_cur);
    end
`ifdef PIX_FRAME_SUM_EN
    total++;
    if (o_sum_strb !== sum_strb_cur || o_sum !== sum_cur) begin
      bad++;
      $display("FAIL frame_sum: got sum=%h strb=%0b want sum=%h strb=%0b",
               o_sum, o_sum_strb, sum_cur, sum_strb_cur);
    end
`endif
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got word=%h want no word", o_word);
      end else begin
        e = exp_q.pop_front();
        if (o_word !== e.w || o_eol !== e.eol || o_eof !== e.eof) begin
          bad++;
          $display("FAIL word: got %h eol=%0b eof=%0b want %h eol=%0b eof=%0b",
                   o_word, o_eol, o_eof, e.w, e.eol, e.eof);
        end else begin
          $display("pop word=%h eol=%0b eof=%0b", o_word, o_eol, o_eof);
        end
      end
    end
  end

  initial begin
    logic [7:0] grp_vals [4];
    grp_vals[0] = 8'h11; grp_vals[1] = 8'h22; grp_vals[2] = 8'h33; grp_vals[3] = 8'h44;

    @(posedge clk);
    #1;
    pulse_reset();

    // Single group, sparse strobes, always ready: expect 0x44332211.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, grp_vals[i], 1'b1, 1'b0);
      repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Two full ramp frames, strobe every third cycle, always ready.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int p = 0; p < 2 * W * H; p++) begin
      step(1'b1, 8'(p), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Overflow: 24 back-to-back pixels with no drain, then drain.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int p = 0; p < 24; p++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full FIFO with a pop on the push cycle: no drop.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int p = 0; p < 19; p++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset after two pixels of a line, then a fresh group.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    step(1'b1, 8'hA2, 1'b1, 1'b0);
    pulse_reset();
    for (int p = 0; p < 4; p++) step(1'b1, 8'(8'hB0 + p), 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Constant-one frame with a clear part-way through the previous one.
    for (int p = 0; p < 20; p++) step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int p = 0; p < W * H; p++) step(1'b1, 8'h01, 1'b1, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional clears.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 199) == 0);
    end
    repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
